// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, runs the fetch req/ack handshake and computes next PC.
// Optional jump-register alignment trap is enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_PC   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [15:0] imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        misaligned
);

    // state | meaning
    // BOOT  | post-reset cycle, no request issued
    // REQ   | fetch request outstanding at pc, waiting for ack
    // HOLD  | pipeline stalled after an accepted fetch, request withdrawn
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic [31:0] next_pc;
    logic        next_non_seq;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        misaligned_q, misaligned_d;
    logic        jr_bad;
`endif

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign jr_bad = jr && (jr_target[1:0] != 2'b00);
`endif

    always_comb begin
        next_pc      = pc_plus4;
        next_non_seq = 1'b1;
        if (jr) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            next_pc = jr_bad ? EXC_PC : jr_target;
`else
            next_pc = jr_target;
`endif
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch && branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_non_seq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        misaligned_d = 1'b0;
`endif
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (fetch_ack) begin
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        pc_d       = next_pc;
                        redirect_d = next_non_seq;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                        misaligned_d = jr_bad;
`endif
                    end
                end
            end
            HOLD: begin
                if (!stall) state_d = REQ;
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_req  = (state_q == REQ);
        fetch_addr = pc_q;
        pc         = pc_q;
        redirect   = redirect_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        misaligned = misaligned_q;
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations are hand-computed, follows PC_SEQ_ALIGN_CHECK_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        branch_taken;
    logic [15:0] imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        misaligned;

    int n_total = 0;
    int n_fail  = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .branch_taken(branch_taken), .imm(imm), .jump(jump),
        .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ctl_clear();
        stall = 0; branch = 0; branch_taken = 0; imm = 16'h0;
        jump = 0; jump_index = 26'h0; jr = 0; jr_target = 32'h0;
    endtask

    // Accepted jr to an aligned address: used to place pc anywhere.
    task automatic load_pc(input logic [31:0] target);
        ctl_clear();
        fetch_ack = 1; jr = 1; jr_target = target;
        step();
        ctl_clear();
    endtask

    initial begin
        reset = 1; fetch_ack = 0;
        ctl_clear();
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, fetch_req}, 32'd0);
        chk("rst_redirect", {31'b0, redirect}, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);

        reset = 0; fetch_ack = 1;
        chk("boot_req", {31'b0, fetch_req}, 32'd0);
        step();
        chk("seq0_req", {31'b0, fetch_req}, 32'd1);
        chk("seq0_addr", fetch_addr, 32'h0);
        step();
        chk("seq1_addr", fetch_addr, 32'h4);
        chk("seq1_req", {31'b0, fetch_req}, 32'd1);
        step();
        chk("seq2_addr", fetch_addr, 32'h8);
        step();
        chk("seq3_addr", fetch_addr, 32'hC);
        chk("seq3_pc_plus4", pc_plus4, 32'h10);
        chk("seq_redirect", {31'b0, redirect}, 32'd0);

        // Taken branch backwards by two words
        load_pc(32'h100);
        chk("jr_load_pc", pc, 32'h100);
        chk("jr_redirect", {31'b0, redirect}, 32'd1);
        branch = 1; branch_taken = 1; imm = 16'hFFFE;
        step();
        chk("br_taken_pc", pc, 32'h0FC);
        chk("br_taken_redirect", {31'b0, redirect}, 32'd1);

        load_pc(32'h100);
        branch = 1; branch_taken = 0; imm = 16'hFFFE;
        step();
        chk("br_not_taken_pc", pc, 32'h104);
        chk("br_not_taken_redirect", {31'b0, redirect}, 32'd0);

        branch = 1; branch_taken = 1; imm = 16'h0010;
        step();
        chk("br_fwd_pc", pc, 32'h148);

        // Jump beats a taken branch
        load_pc(32'h9000_0010);
        jump = 1; jump_index = 26'h0000040; branch = 1; branch_taken = 1; imm = 16'h0004;
        step();
        chk("jump_pc", pc, 32'h9000_0100);
        chk("jump_redirect", {31'b0, redirect}, 32'd1);

        // jr beats jump and branch
        ctl_clear();
        jr = 1; jr_target = 32'h0000_0200; jump = 1; jump_index = 26'h3FFFFFF;
        branch = 1; branch_taken = 1; imm = 16'h0100;
        step();
        chk("jr_prio_pc", pc, 32'h200);

        // Sequential wrap at top of address space
        load_pc(32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_redirect", {31'b0, redirect}, 32'd0);

        // Ack withheld, then stalled ack, then re-issue
        load_pc(32'h20);
        fetch_ack = 0;
        step();
        chk("wait1_addr", fetch_addr, 32'h20);
        chk("wait1_req", {31'b0, fetch_req}, 32'd1);
        step();
        chk("wait2_addr", fetch_addr, 32'h20);
        step();
        chk("wait3_addr", fetch_addr, 32'h20);
        chk("wait3_req", {31'b0, fetch_req}, 32'd1);
        fetch_ack = 1; stall = 1;
        step();
        chk("hold1_req", {31'b0, fetch_req}, 32'd0);
        chk("hold1_addr", fetch_addr, 32'h20);
        step();
        chk("hold2_req", {31'b0, fetch_req}, 32'd0);
        chk("hold2_pc", pc, 32'h20);
        stall = 0;
        step();
        chk("reissue_req", {31'b0, fetch_req}, 32'd1);
        chk("reissue_addr", fetch_addr, 32'h20);
        step();
        chk("advance_addr", fetch_addr, 32'h24);

        // Misaligned jump-register target
        ctl_clear();
        jr = 1; jr_target = 32'h0000_0042;
        step();
`ifdef PC_SEQ_ALIGN_CHECK_EN
        chk("jr_mis_pc", pc, 32'h8000_0180);
        chk("jr_mis_flag", {31'b0, misaligned}, 32'd1);
`else
        chk("jr_mis_pc", pc, 32'h0000_0042);
        chk("jr_mis_flag", {31'b0, misaligned}, 32'd0);
`endif
        chk("jr_mis_redirect", {31'b0, redirect}, 32'd1);
        ctl_clear();
        step();
        chk("jr_mis_pulse_end", {31'b0, misaligned}, 32'd0);
        chk("redirect_pulse_end", {31'b0, redirect}, 32'd0);

        // Reset while in HOLD
        load_pc(32'h400);
        stall = 1;
        step();
        chk("pre_rst_hold_req", {31'b0, fetch_req}, 32'd0);
        chk("pre_rst_hold_pc", pc, 32'h400);
        reset = 1;
        step();
        chk("hold_rst_pc", pc, 32'h0);
        chk("hold_rst_req", {31'b0, fetch_req}, 32'd0);
        reset = 0; stall = 0;
        step();
        chk("post_rst_req", {31'b0, fetch_req}, 32'd1);
        chk("post_rst_addr", fetch_addr, 32'h0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS datapath. Holds the PC, issues instruction-fetch requests with a req/ack handshake, and selects the next PC from sequential, branch (sign-extended offset shifted left 2), jump (index shifted left 2) and jump-register targets. Sits between the decode/control unit and instruction memory, and owns all next-PC arithmetic the shift-left-2 datapath feeds.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- EXC_PC, 32'h8000_0180, PC loaded on a misaligned jump-register target (only with PC_SEQ_ALIGN_CHECK_EN)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; blocks the PC update
- branch  in  1  current instruction is a conditional branch
- branch_taken  in  1  branch condition true (ignored unless branch=1)
- imm  in  16  branch offset in words
- jump  in  1  J/JAL
- jump_index  in  26  jump target index
- jr  in  1  JR/JALR
- jr_target  in  32  register target for jr
- fetch_req  out  1  fetch request valid
- fetch_addr  out  32  fetch address (equals pc)
- fetch_ack  in  1  instruction memory accepted the request
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational from pc
- redirect  out  1  one-cycle pulse: last PC update was non-sequential
- misaligned  out  1  one-cycle pulse: jr_target[1:0] != 0 (macro only; tied 0 otherwise)

## Operation
- States: BOOT, REQ, HOLD.
- BOOT: entered on reset; fetch_req=0; unconditionally goes to REQ next cycle.
- REQ: fetch_req=1, fetch_addr=pc. Control inputs are sampled only on a cycle with fetch_ack=1.
  - fetch_ack=1, stall=0: pc <= next_pc; stay in REQ.
  - fetch_ack=1, stall=1: pc unchanged; go to HOLD.
  - fetch_ack=0: pc unchanged; stay in REQ; request stays asserted with stable address.
- HOLD: fetch_req=0; fetch_ack ignored; stall=0 -> REQ (re-issues the same pc); stall=1 -> stay.
- next_pc priority (highest first): jr, jump, branch&&branch_taken, sequential.
  - sequential: pc_plus4.
  - branch: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), 32-bit modulo 2^32, wraps silently.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - jr: jr_target.
- Simultaneous jr/jump/branch: only the highest-priority source takes effect.
- pc_plus4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- redirect is 1 in the cycle after any update that did not select the sequential source; otherwise 0.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, fetch_req=0, redirect=0, misaligned=0.
- First fetch_req=1 one cycle after reset deasserts.
- Zero-wait memory: fetch_ack may be high in the same cycle fetch_req rises; one instruction per cycle sustained.
- pc/fetch_addr update on the edge where fetch_ack=1 and stall=0; new address visible the next cycle.
- reset mid-operation (any state, any handshake phase) overrides everything at the next edge; in-flight request is abandoned.
- fetch_addr is registered; pc_plus4 and next_pc are combinational from pc and inputs.

## Configuration
- PC_SEQ_ALIGN_CHECK_EN defined: on an accepted update with jr=1 and jr_target[1:0]!=0, pc <= EXC_PC, misaligned pulses 1 cycle, redirect pulses 1 cycle.
- Undefined: jr_target loaded verbatim (low bits included); misaligned tied 0.

## Test plan
- Reset then ack every cycle, no control: fetch_addr 0x0, 0x4, 0x8, 0xC on successive cycles; fetch_req low only in the BOOT cycle.
- pc=0x100, branch=1, branch_taken=1, imm=16'hFFFE, ack -> pc=0x0FC, redirect=1; same with branch_taken=0 -> pc=0x104, redirect=0.
- pc=0x9000_0010, jump=1, jump_index=26'h0000040, with branch taken also asserted -> pc=0x9000_0100 (jump wins).
- pc=0x20, ack withheld 3 cycles then ack with stall=1 for 2 cycles -> fetch_addr holds 0x20, fetch_req drops in HOLD, re-issues 0x20, advances to 0x24 on next unstalled ack.
- jr=1, jr_target=0x0000_0042, ack: with PC_SEQ_ALIGN_CHECK_EN -> pc=0x8000_0180, misaligned=1; without -> pc=0x0000_0042, misaligned=0.
- reset asserted in HOLD with pc=0x400 -> next cycle pc=RESET_PC, fetch_req=0, state BOOT.
